// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with registered read ports and a per-register busy scoreboard; define REGFILE_BYPASS_EN for write-to-read forwarding
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   busy_set_en,
  input  logic [AW-1:0]          busy_set_addr,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  output logic                   any_busy
);
  localparam logic [AW:0] NR = NUM_REGS[AW:0];
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_RD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0] rd_busy_q, rd_busy_d;
  logic any_busy_q;
  logic wr_ok, set_ok;
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NR;
  endfunction
  // x0 and out-of-range addresses never take writes or busy marks
  assign wr_ok = wr_en && wr_addr != '0 && in_range(wr_addr);
  assign set_ok = busy_set_en && busy_set_addr != '0 && in_range(busy_set_addr);
  // architectural registers; x0 is never written so it stays zero
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    else if (wr_ok) regs_q[wr_addr] <= wr_data;
  // writeback clears, issue sets; set is applied last so it wins on a collision
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) busy_d[wr_addr] = 1'b0;
    if (set_ok) busy_d[busy_set_addr] = 1'b1;
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic ok;
    assign a = rd_addr[i*AW +: AW];
    assign ok = in_range(a);
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wr_ok && wr_addr == a;
    assign rd_data_d[i*XLEN +: XLEN] = hit ? wr_data : ok ? regs_q[a] : '0;
    assign rd_busy_d[i] = hit ? busy_d[a] : ok && busy_q[a];
`else
    assign rd_data_d[i*XLEN +: XLEN] = ok ? regs_q[a] : '0;
    assign rd_busy_d[i] = ok && busy_q[a];
`endif
  end
  // scoreboard state and registered read outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_q <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
      any_busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
      any_busy_q <= |busy_d;
    end
  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;
  assign any_busy = any_busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed bench with a behavioural register-file model checked every cycle
module tb_regfile_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic wr_en = 0, set_en = 0;
  logic [4:0] wr_addr = 0, set_addr = 0;
  logic [31:0] wr_data = 0;
  logic [9:0] rd_addr = 0;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic any_busy;
  regfile_scoreboard dut (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set_en(set_en), .busy_set_addr(set_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .any_busy(any_busy));
  logic w_wr_en = 0;
  logic [4:0] w_wr_addr = 0;
  logic [63:0] w_wr_data = 0;
  logic [14:0] w_rd_addr = 0;
  logic [191:0] w_rd_data;
  logic [2:0] w_rd_busy;
  logic w_any;
  regfile_scoreboard #(.XLEN(64), .NUM_REGS(32), .NUM_RD(3)) dut_w (.clk(clk), .rst(rst), .wr_en(w_wr_en),
    .wr_addr(w_wr_addr), .wr_data(w_wr_data), .busy_set_en(1'b0), .busy_set_addr(5'd0), .rd_addr(w_rd_addr),
    .rd_data(w_rd_data), .rd_busy(w_rd_busy), .any_busy(w_any));
  logic o_wr_en = 0, o_set_en = 0;
  logic [4:0] o_wr_addr = 0, o_set_addr = 0, o_rd_addr = 0;
  logic [31:0] o_wr_data = 0;
  logic [31:0] o_rd_data;
  logic [0:0] o_rd_busy;
  logic o_any;
  regfile_scoreboard #(.XLEN(32), .NUM_REGS(17), .NUM_RD(1)) dut_o (.clk(clk), .rst(rst), .wr_en(o_wr_en),
    .wr_addr(o_wr_addr), .wr_data(o_wr_data), .busy_set_en(o_set_en), .busy_set_addr(o_set_addr),
    .rd_addr(o_rd_addr), .rd_data(o_rd_data), .rd_busy(o_rd_busy), .any_busy(o_any));
  logic [31:0] m_reg [32];
  logic m_busy [32];
  logic [63:0] e_data;
  logic [1:0] e_busy;
  logic e_any;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin
      m_reg[k] = 0;
      m_busy[k] = 0;
    end
    e_data = 0;
    e_busy = 0;
    e_any = 0;
  endtask
  task automatic step();
    logic [31:0] nr [32];
    logic nb [32];
    logic [63:0] d;
    logic [1:0] b;
    logic any;
    logic [4:0] a;
    nr = m_reg;
    nb = m_busy;
    if (wr_en && wr_addr != 0) begin
      nr[wr_addr] = wr_data;
      nb[wr_addr] = 0;
    end
    if (set_en && set_addr != 0) nb[set_addr] = 1;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      d[p*32 +: 32] = m_reg[a];
      b[p] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && a != 0 && wr_addr == a) begin
        d[p*32 +: 32] = nr[a];
        b[p] = nb[a];
      end
`endif
    end
    any = 0;
    for (int k = 0; k < 32; k++) any |= nb[k];
    @(posedge clk);
    m_reg = nr;
    m_busy = nb;
    e_data = d;
    e_busy = b;
    e_any = any;
    #1;
  endtask
  always @(negedge clk) begin
    chk("rd_data", rd_data, e_data);
    chk("rd_busy", rd_busy, e_busy);
    chk("any_busy", any_busy, e_any);
  end
  initial begin
    logic [31:0] raw_exp;
`ifdef REGFILE_BYPASS_EN
    raw_exp = 32'h22;
`else
    raw_exp = 32'h11;
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset rd_data", rd_data, 0);
    chk("reset any_busy", any_busy, 0);
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
    w_wr_en = 1; w_wr_addr = 31; w_wr_data = 64'h0123_4567_89AB_CDEF;
    step();
    wr_en = 0; rd_addr = {5'd0, 5'd5};
    w_wr_en = 0; w_rd_addr = {5'd31, 5'd3, 5'd0};
    chk("wide port2 before read", w_rd_data[128 +: 64], 0);
    step();
    chk("x5 before reset", rd_data[31:0], 32'hDEAD_BEEF);
    chk("wide port2 x31", w_rd_data[128 +: 64], 64'h0123_4567_89AB_CDEF);
    chk("wide port0 x0", w_rd_data[63:0], 0);
    chk("wide busy", {w_any, w_rd_busy}, 0);
    #2 rst = 1;
    model_clear();
    #1 chk("async reset rd_data", rd_data, 0);
    @(posedge clk);
    #1 rst = 0;
    step();
    chk("x5 after reset", rd_data[31:0], 0);
    chk("x5 busy after reset", rd_busy[0], 0);
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234_5678; set_en = 1; set_addr = 0; rd_addr = 0;
    step();
    wr_en = 0; set_en = 0;
    step();
    chk("x0 both ports", rd_data, 0);
    chk("x0 never busy", {any_busy, rd_busy}, 0);
    wr_en = 1; wr_addr = 3; wr_data = 32'h0000_00A5;
    step();
    wr_en = 0; rd_addr = {5'd3, 5'd3};
    step();
    chk("x3 both ports", rd_data, {2{32'h0000_00A5}});
    wr_en = 1; wr_addr = 7; wr_data = 32'h11; rd_addr = {5'd3, 5'd0};
    step();
    wr_data = 32'h22; rd_addr = {5'd3, 5'd7};
    step();
    chk("raw same cycle", rd_data[31:0], raw_exp);
    chk("raw other port", rd_data[63:32], 32'hA5);
    wr_en = 0;
    step();
    chk("raw next read", rd_data[31:0], 32'h22);
    set_en = 1; set_addr = 9; rd_addr = {5'd3, 5'd9};
    step();
    set_en = 0;
    step();
    chk("x9 busy", rd_busy, 2'b01);
    chk("x9 any_busy", any_busy, 1);
    wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    step();
    wr_en = 0;
    step();
    chk("x9 cleared", rd_busy[0], 0);
    chk("x9 any cleared", any_busy, 0);
    chk("x9 data", rd_data[31:0], 32'h99);
    set_en = 1; set_addr = 9;
    step();
    wr_en = 1; wr_addr = 9; wr_data = 32'h9A;
    step();
    wr_en = 0; set_en = 0;
    step();
    chk("x9 set wins", rd_busy[0], 1);
    chk("x9 set wins any", any_busy, 1);
    chk("x9 new data", rd_data[31:0], 32'h9A);
    wr_en = 1; wr_addr = 9; wr_data = 32'h9B;
    step();
    wr_en = 0;
    o_wr_en = 1; o_wr_addr = 17; o_wr_data = 32'hFFFF_FFFF; o_set_en = 1; o_set_addr = 17;
    step();
    o_wr_en = 0; o_set_en = 0; o_rd_addr = 17;
    step();
    chk("oor read data", o_rd_data, 0);
    chk("oor read busy", {o_any, o_rd_busy}, 0);
    o_rd_addr = 1;
    step();
    chk("oor no alias x1", o_rd_data, 0);
    o_wr_en = 1; o_wr_addr = 16; o_wr_data = 32'h55;
    step();
    o_wr_en = 0; o_rd_addr = 16;
    step();
    chk("top valid x16", o_rd_data, 32'h55);
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
